sw_job_scheduler: RTL and testbench

SW_JOB_SCHEDULER -- requirements
Module: sw_job_scheduler

---
 rtl/sw_job_scheduler.sv | 178 +++++++++++++++++
 tb/tb_sw_job_scheduler.sv | 366 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sw_job_scheduler.sv
// Job scheduler for a banded Smith-Waterman accelerator: queues jobs,
// sequences the accelerator with blanking and timeout, returns results in order.
module sw_job_scheduler #(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 1000,
    parameter int BLANK   = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [23:0] in_r,
    input  logic [23:0] in_q,
    input  logic [3:0]  in_tag,
    output logic        acc_start,
    output logic [23:0] acc_r,
    output logic [23:0] acc_q,
    input  logic        acc_ready,
    input  logic [29:0] acc_r_aligned,
    input  logic [29:0] acc_q_aligned,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [29:0] out_r_aligned,
    output logic [29:0] out_q_aligned,
    output logic [3:0]  out_tag,
    output logic        out_err,
    output logic        busy,
    output logic [15:0] jobs_done
);
    localparam int AW   = $clog2(DEPTH);
    localparam int CW   = $clog2(DEPTH + 1);
    localparam int MAXC = (TIMEOUT > BLANK) ? TIMEOUT : BLANK;
    localparam int TW   = $clog2(MAXC + 2);

    localparam logic [CW-1:0] FULL   = CW'(DEPTH);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);
    localparam logic [TW-1:0] B_LAST = TW'(BLANK);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_BLANK,
        ST_WAIT,
        ST_HOLD
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [23:0]   mem_r   [DEPTH];
    logic [23:0]   mem_q   [DEPTH];
    logic [3:0]    mem_tag [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;

    logic [23:0]   job_r;
    logic [23:0]   job_q;
    logic [3:0]    job_tag;
    logic [TW-1:0] cnt;

    logic push;
    logic pop;
    logic load_job;
    logic take_ok;
    logic take_err;
    logic retire;

    // Full flag depends only on the registered count, never on a same-cycle pop.
    assign in_ready = count < FULL;
    assign push     = in_valid && in_ready;
    assign pop      = state == ST_START;
    assign load_job = state_nxt == ST_START;

    always_ff @(posedge clk) begin
        if (push) begin
            mem_r[wr_ptr]   <= in_r;
            mem_q[wr_ptr]   <= in_q;
            mem_tag[wr_ptr] <= in_tag;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_comb begin
        state_nxt = state;
        take_ok   = 1'b0;
        take_err  = 1'b0;
        retire    = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (count != '0) state_nxt = ST_START;
            end
            ST_START: begin
                state_nxt = (BLANK > 0) ? ST_BLANK : ST_WAIT;
            end
            ST_BLANK: begin
                if (cnt >= B_LAST) state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                // A completion in the timeout cycle still counts as success.
                if (acc_ready) begin
                    take_ok   = 1'b1;
                    state_nxt = ST_HOLD;
                end else if (cnt >= T_LAST) begin
                    take_err  = 1'b1;
                    state_nxt = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (out_ready) begin
                    retire    = 1'b1;
                    state_nxt = (count != '0) ? ST_START : ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= ST_IDLE;
            job_r         <= '0;
            job_q         <= '0;
            job_tag       <= '0;
            cnt           <= '0;
            out_r_aligned <= '0;
            out_q_aligned <= '0;
            out_err       <= 1'b0;
            jobs_done     <= '0;
        end else begin
            state <= state_nxt;
            if (load_job) begin
                job_r   <= mem_r[rd_ptr];
                job_q   <= mem_q[rd_ptr];
                job_tag <= mem_tag[rd_ptr];
            end
            // cnt holds the number of cycles elapsed since the START cycle.
            if (state == ST_START) begin
                cnt <= TW'(1);
            end else if (state == ST_BLANK || state == ST_WAIT) begin
                cnt <= cnt + 1'b1;
            end
            if (take_ok) begin
                out_r_aligned <= acc_r_aligned;
                out_q_aligned <= acc_q_aligned;
                out_err       <= 1'b0;
            end else if (take_err) begin
                out_r_aligned <= '0;
                out_q_aligned <= '0;
                out_err       <= 1'b1;
            end
            if (retire) jobs_done <= jobs_done + 1'b1;
        end
    end

    assign acc_start = state == ST_START;
    assign acc_r     = job_r;
    assign acc_q     = job_q;
    assign out_tag   = job_tag;
    assign out_valid = state == ST_HOLD;
    assign busy      = state != ST_IDLE;

endmodule

// File: tb/tb_sw_job_scheduler.sv
// Bench for sw_job_scheduler: vector table, corner sequences and random
// traffic against an in-order result queue and a latency-driven accelerator model.
module tb_sw_job_scheduler;
    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 1000;
    localparam int BLANK   = 2;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        in_valid;
    logic        in_ready;
    logic [23:0] in_r;
    logic [23:0] in_q;
    logic [3:0]  in_tag;
    logic        acc_start;
    logic [23:0] acc_r;
    logic [23:0] acc_q;
    logic        acc_ready = 1'b0;
    logic [29:0] acc_r_aligned = '0;
    logic [29:0] acc_q_aligned = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [29:0] out_r_aligned;
    logic [29:0] out_q_aligned;
    logic [3:0]  out_tag;
    logic        out_err;
    logic        busy;
    logic [15:0] jobs_done;

    sw_job_scheduler #(.DEPTH(DEPTH), .TIMEOUT(TIMEOUT), .BLANK(BLANK)) dut (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_r(in_r), .in_q(in_q), .in_tag(in_tag),
        .acc_start(acc_start), .acc_r(acc_r), .acc_q(acc_q),
        .acc_ready(acc_ready),
        .acc_r_aligned(acc_r_aligned), .acc_q_aligned(acc_q_aligned),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_r_aligned(out_r_aligned), .out_q_aligned(out_q_aligned),
        .out_tag(out_tag), .out_err(out_err),
        .busy(busy), .jobs_done(jobs_done)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [29:0] ra;
        logic [29:0] qa;
        logic [3:0]  tag;
        logic        err;
    } res_t;

    typedef struct {
        logic [23:0] r;
        logic [23:0] q;
        logic [3:0]  tag;
        int          lat;
        bit          stale;
        res_t        exp;
        int          dly;
    } vec_t;

    res_t exp_q[$];
    int   lat_q[$];
    bit   stale_q[$];
    int   checks = 0;
    int   errors = 0;
    logic [15:0] exp_done = '0;
    int   rdy_mode = 0;
    int   acc_starts = 0;

    function automatic void chk(input string name, input logic [63:0] act,
                                input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d",
                     name, act, exp, cyc);
        end
    endfunction

    function automatic bit job_ok(input int lat);
        return lat >= 1 && lat <= TIMEOUT - 1;
    endfunction

    // Result the accelerator produces for a completed job.
    function automatic res_t model(input logic [23:0] r, input logic [23:0] q,
                                   input logic [3:0] tag, input int lat);
        res_t e;
        e.tag = tag;
        e.err = !job_ok(lat);
        e.ra  = job_ok(lat) ? {r, 6'h15} : 30'h0;
        e.qa  = job_ok(lat) ? {6'h2A, q} : 30'h0;
        return e;
    endfunction

    // Cycles from the START cycle to the first HOLD cycle.
    function automatic int delay(input int lat);
        int w;
        w = (lat > BLANK + 1) ? lat : BLANK + 1;
        return job_ok(lat) ? w + 1 : TIMEOUT;
    endfunction

    function automatic vec_t mk(input logic [23:0] r, input logic [23:0] q,
                                input logic [3:0] tag, input int lat,
                                input bit stale);
        vec_t v;
        v.r = r;
        v.q = q;
        v.tag = tag;
        v.lat = lat;
        v.stale = stale;
        v.exp = model(r, q, tag, lat);
        v.dly = delay(lat);
        return v;
    endfunction

    // Accelerator model: raises ready lat cycles after the start pulse.
    int          t;
    int          cur_lat;
    bit          cur_stale;
    bit          running = 0;
    bit          good = 0;
    logic [23:0] mr;
    logic [23:0] mq;
    always @(negedge clk) begin
        if (!reset_n) begin
            running = 0;
            good = 0;
            acc_ready = 1'b0;
        end else if (acc_start) begin
            acc_starts++;
            mr = acc_r;
            mq = acc_q;
            t = 0;
            running = 1;
            good = 0;
            cur_lat = (lat_q.size() > 0) ? lat_q.pop_front() : -1;
            cur_stale = (stale_q.size() > 0) ? stale_q.pop_front() : 1'b0;
            acc_ready = cur_stale;
        end else if (running) begin
            t++;
            chk("acc_data_stable", {acc_r, acc_q}, {mr, mq});
            if (cur_stale && t == 3 && !good) acc_ready = 1'b0;
            if (t == cur_lat) begin
                acc_ready = 1'b1;
                good = 1;
                running = 0;
            end
        end
        acc_r_aligned = good ? {mr, 6'h15} : 30'h15A5C3C3;
        acc_q_aligned = good ? {6'h2A, mq} : 30'h0A5A3C3C;
    end

    // Result monitor: drives out_ready, checks order, data and stability.
    bit          prev_stall = 0;
    logic [29:0] p_ra;
    logic [29:0] p_qa;
    logic [4:0]  p_te;
    always @(negedge clk) begin
        res_t e;
        if (!reset_n) begin
            out_ready = 1'b0;
            prev_stall = 0;
        end else begin
            out_ready = (rdy_mode == 0) ? 1'b1 :
                        (rdy_mode == 1) ? 1'b0 : 1'($urandom_range(0, 1));
            if (prev_stall) begin
                chk("hold_valid", out_valid, 1);
                chk("hold_r", out_r_aligned, p_ra);
                chk("hold_q", out_q_aligned, p_qa);
                chk("hold_tag_err", {out_tag, out_err}, p_te);
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_result", exp_q.size(), 1);
                end else begin
                    e = exp_q.pop_front();
                    chk("res_r", out_r_aligned, e.ra);
                    chk("res_q", out_q_aligned, e.qa);
                    chk("res_tag", out_tag, e.tag);
                    chk("res_err", out_err, e.err);
                    chk("jobs_done", jobs_done, exp_done);
                    exp_done++;
                end
            end
            prev_stall = out_valid && !out_ready;
            p_ra = out_r_aligned;
            p_qa = out_q_aligned;
            p_te = {out_tag, out_err};
        end
    end

    task automatic submit(input logic [23:0] r, input logic [23:0] q,
                          input logic [3:0] tag, input int lat,
                          input bit stale, output int acc_edge);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_r = r;
        in_q = q;
        in_tag = tag;
        while (!in_ready && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) chk("submit_wait", in_ready, 1);
        acc_edge = int'(cyc) + 1;
        exp_q.push_back(model(r, q, tag, lat));
        lat_q.push_back(lat);
        stale_q.push_back(stale);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(input int lim, output int at);
        int n;
        n = 0;
        while (!out_valid && n < lim) begin
            @(negedge clk);
            n++;
        end
        chk("valid_wait", out_valid, 1);
        at = int'(cyc);
    endtask

    task automatic wait_drain(input int lim);
        int n;
        n = 0;
        while (exp_q.size() > 0 && n < lim) begin
            @(negedge clk);
            n++;
        end
        chk("drain", exp_q.size(), 0);
        @(negedge clk);
    endtask

    vec_t vecs[8];

    initial begin
        int ae;
        int a0;
        int s;
        int vc;
        int rel;
        int bad;
        int starts0;
        int lat;
        bit st;

        vecs[0] = mk(24'hABCDEF, 24'hABCDEE, 4'd3, 40, 0);
        vecs[1] = mk(24'h000000, 24'hFFFFFF, 4'd15, 3, 0);
        vecs[2] = mk(24'h123456, 24'h654321, 4'd5, 1, 0);
        vecs[3] = mk(24'hFFFFFF, 24'h000000, 4'd7, 20, 1);
        vecs[4] = mk(24'h5A5A5A, 24'hA5A5A5, 4'd1, TIMEOUT - 1, 0);
        vecs[5] = mk(24'h111111, 24'h222222, 4'd2, -1, 0);
        vecs[6] = mk(24'h333333, 24'h444444, 4'd4, TIMEOUT, 0);
        vecs[7] = mk(24'hC0FFEE, 24'hBADA55, 4'd9, 10, 0);

        in_valid = 1'b0;
        in_r = '0;
        in_q = '0;
        in_tag = '0;

        #2 reset_n = 1'b0;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_acc_start", acc_start, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", out_err, 0);
        chk("rst_jobs_done", jobs_done, 0);
        chk("rst_out_data", {out_r_aligned, out_q_aligned}, 0);
        chk("rst_acc_data", {acc_r, acc_q, out_tag}, 0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        rel = int'(cyc);
        chk("rst_in_ready", in_ready, 1);

        for (int i = 0; i < 8; i++) begin
            submit(vecs[i].r, vecs[i].q, vecs[i].tag, vecs[i].lat,
                   vecs[i].stale, ae);
            if (i == 0) chk("first_push_edge", ae, rel + 1);
            chk("idle_no_start", acc_start, 0);
            @(negedge clk);
            chk("start_cycle2", acc_start, 1);
            s = int'(cyc);
            @(negedge clk);
            chk("start_pulse", acc_start, 0);
            wait_valid(TIMEOUT + 100, vc);
            chk("result_delay", vc - s, vecs[i].dly);
            wait_drain(10);
            @(negedge clk);
            chk("idle_busy", busy, 0);
        end

        // Fill the queue back-to-back behind a slow job.
        a0 = 0;
        for (int k = 0; k < 5; k++) begin
            submit(24'h100000 + 24'(k), 24'h200000 + 24'(k), 4'(k), 30, 0, ae);
            if (k == 0) a0 = ae;
            else chk("fill_b2b", ae, a0 + k);
        end
        chk("fill_full", in_ready, 0);
        wait_drain(5 * 40 + 20);

        // Output backpressure with a second job waiting.
        rdy_mode = 1;
        submit(24'h0F0F0F, 24'hF0F0F0, 4'd10, 5, 0, ae);
        submit(24'h00FF00, 24'hFF00FF, 4'd11, 5, 0, ae);
        wait_valid(100, vc);
        starts0 = acc_starts;
        repeat (20) @(negedge clk);
        chk("bp_valid", out_valid, 1);
        chk("bp_no_start", acc_starts, starts0);
        rdy_mode = 0;
        wait_drain(100);

        // Reset in the middle of WAIT with two jobs queued.
        for (int k = 0; k < 3; k++) begin
            submit(24'h777000 + 24'(k), 24'h888000 + 24'(k), 4'(12 + k), 500, 0, ae);
        end
        repeat (10) @(negedge clk);
        reset_n = 1'b0;
        exp_q.delete();
        lat_q.delete();
        stale_q.delete();
        exp_done = '0;
        #1;
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_jobs_done", jobs_done, 0);
        chk("mid_rst_in_ready", in_ready, 1);
        chk("mid_rst_acc", {acc_r, acc_q}, 0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        bad = 0;
        repeat (30) begin
            @(negedge clk);
            if (out_valid || acc_start || busy) bad++;
        end
        chk("mid_rst_quiet", bad, 0);
        submit(24'h246802, 24'h135791, 4'd6, 12, 0, ae);
        @(negedge clk);
        chk("mid_rst_start_cycle2", acc_start, 1);
        wait_drain(60);

        // Random traffic against the in-order reference queue.
        rdy_mode = 2;
        for (int j = 0; j < 40; j++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            lat = ($urandom_range(0, 11) == 0) ? -1 : int'($urandom_range(1, 40));
            st = (lat > 6) && ($urandom_range(0, 3) == 0);
            submit(24'($urandom), 24'($urandom), 4'($urandom), lat, st, ae);
        end
        wait_drain(40 * (TIMEOUT + 50));
        rdy_mode = 0;
        @(negedge clk);
        chk("final_jobs_done", jobs_done, exp_done);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
